alarm_timekeeper: RTL and testbench

Time-of-day counter and alarm controller for the alarm-clock module. It sits directly downstream of the clock divider: it takes the divider's 1 Hz output, counts seconds, minutes and hours in 24-hour format, and holds a settable alarm time. An alarm state machine raises `alarm_ring` when the time reaches the alarm time and handles snooze and dismiss. Outputs feed the display and buzzer stages.

---
 rtl/alarm_timekeeper.sv | 162 ++++++++++++++++
 tb/tb_alarm_timekeeper.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timekeeper.sv
// Time-of-day counter (24 h) with a settable alarm, snooze and ring timeout.
// Advances on each rising edge of the divider tick and makes no assumption about the tick rate.
module alarm_timekeeper #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_pulse,
  output logic       alarm_ring,
  output logic       snoozing
);

  localparam int SNOOZE_W = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int RING_W   = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD = SNOOZE_W'(SNOOZE_MIN * 60);
  localparam logic [RING_W-1:0]   RING_LIMIT  = RING_W'(RING_TIMEOUT_S);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  state_e              state, state_nx;
  logic                tick_prev;
  logic [4:0]          alarm_hour;
  logic [5:0]          alarm_min;
  logic [RING_W-1:0]   ring_cnt, ring_cnt_nx;
  logic [SNOOZE_W-1:0] snooze_cnt, snooze_cnt_nx;

  logic       load_ok, time_load, alarm_load;
  logic       tick, tick_adv, match;
  logic [4:0] adv_hour;
  logic [5:0] adv_min, adv_sec;

  assign load_ok    = (set_hour <= 5'd23) && (set_min <= 6'd59);
  assign time_load  = set_time && load_ok;
  assign alarm_load = set_alarm && load_ok;
  assign tick       = tick_in && !tick_prev;
  // A valid time load swallows a coincident tick, including its effect on the alarm counters.
  assign tick_adv   = tick && !time_load;

  // NOTE: always_comb gives every output a default first so no path can infer a latch.
  always_comb begin
    adv_sec  = seconds + 6'd1;
    adv_min  = minutes;
    adv_hour = hours;
    if (seconds == 6'd59) begin
      adv_sec = '0;
      if (minutes == 6'd59) begin
        adv_min  = '0;
        adv_hour = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      end else begin
        adv_min = minutes + 6'd1;
      end
    end
  end

  assign match = tick_adv && (adv_sec == 6'd0) && (adv_min == alarm_min) &&
                 (adv_hour == alarm_hour);

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_prev  <= 1'b0;
      sec_pulse  <= 1'b0;
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      alarm_hour <= '0;
      alarm_min  <= '0;
    end else begin
      tick_prev <= tick_in;
      sec_pulse <= tick_adv;
      if (time_load) begin
        hours   <= set_hour;
        minutes <= set_min;
        seconds <= '0;
      end else if (tick_adv) begin
        hours   <= adv_hour;
        minutes <= adv_min;
        seconds <= adv_sec;
      end
      if (alarm_load) begin
        alarm_hour <= set_hour;
        alarm_min  <= set_min;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
    end else begin
      state      <= state_nx;
      ring_cnt   <= ring_cnt_nx;
      snooze_cnt <= snooze_cnt_nx;
    end
  end

  // Priority: alarm_en low > valid set_alarm > dismiss > snooze > tick-driven moves.
  always_comb begin
    state_nx      = state;
    ring_cnt_nx   = ring_cnt;
    snooze_cnt_nx = snooze_cnt;
    if (!alarm_en || alarm_load) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state_nx    = RINGING;
            ring_cnt_nx = '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_nx = IDLE;
          end else if (snooze) begin
            state_nx      = SNOOZED;
            snooze_cnt_nx = SNOOZE_LOAD;
          end else if (tick_adv) begin
            ring_cnt_nx = ring_cnt + RING_W'(1);
            if (ring_cnt_nx == RING_LIMIT) state_nx = IDLE;
          end
        end
        SNOOZED: begin
          if (dismiss) begin
            state_nx = IDLE;
          end else if (tick_adv) begin
            snooze_cnt_nx = snooze_cnt - SNOOZE_W'(1);
            if (snooze_cnt_nx == '0) begin
              state_nx    = RINGING;
              ring_cnt_nx = '0;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    alarm_ring = (state == RINGING);
    snoozing   = (state == SNOOZED);
  end

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Self-checking bench for alarm_timekeeper: directed table, corner sequences and
// randomized traffic compared against a seconds-of-day reference model.
module tb_alarm_timekeeper;

  localparam int SNOOZE_MIN     = 5;
  localparam int RING_TIMEOUT_S = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       set_time = 1'b0;
  logic       set_alarm = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic       alarm_en = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_pulse;
  logic       alarm_ring;
  logic       snoozing;

  alarm_timekeeper #(
    .SNOOZE_MIN    (SNOOZE_MIN),
    .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .set_time  (set_time),
    .set_alarm (set_alarm),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .dismiss   (dismiss),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .sec_pulse (sec_pulse),
    .alarm_ring(alarm_ring),
    .snoozing  (snoozing)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  // Reference model: time and alarm as seconds of the day, alarm behaviour as flags.
  int m_t, m_alarm, m_ring_secs, m_snooze_left;
  bit m_prev, m_ring, m_snz, m_pulse;

  typedef struct {
    int tick, st, sa, h, m, en, snz, dis;
    int eh, em, es, ep, er, esn;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_vec(input int h, input int m, input int s,
                                          input int p, input int r, input int sn);
    return 32'((((h * 4096) + (m * 64) + s) * 8) + (p * 4) + (r * 2) + sn);
  endfunction

  function automatic logic [31:0] exp_hms(input int h, input int m, input int s);
    return 32'((h * 4096) + (m * 64) + s);
  endfunction

  function automatic logic [31:0] dut_vec();
    return {12'd0, hours, minutes, seconds, sec_pulse, alarm_ring, snoozing};
  endfunction

  function automatic logic [31:0] dut_hms();
    return {15'd0, hours, minutes, seconds};
  endfunction

  function automatic logic [31:0] model_vec();
    return exp_vec(m_t / 3600, (m_t / 60) % 60, m_t % 60, int'(m_pulse), int'(m_ring),
                   int'(m_snz));
  endfunction

  task automatic model_reset();
    m_t = 0; m_alarm = 0; m_ring_secs = 0; m_snooze_left = 0;
    m_prev = 1'b0; m_ring = 1'b0; m_snz = 1'b0; m_pulse = 1'b0;
  endtask

  // Effect of one clock edge, from the inputs sampled at that edge.
  task automatic model_step();
    bit tk, tv, av, adv, hit;
    int lh, lm;
    lh = int'(set_hour);
    lm = int'(set_min);
    tk = tick_in && !m_prev;
    m_prev = tick_in;
    tv = set_time && lh <= 23 && lm <= 59;
    av = set_alarm && lh <= 23 && lm <= 59;
    adv = tk && !tv;
    hit = 1'b0;
    m_pulse = adv;
    if (tv) m_t = lh * 3600 + lm * 60;
    else if (adv) begin
      m_t = (m_t + 1) % 86400;
      hit = (m_t == m_alarm);
    end
    if (av) m_alarm = lh * 3600 + lm * 60;
    if (!alarm_en || av) begin
      m_ring = 1'b0; m_snz = 1'b0;
    end else if (m_ring) begin
      if (dismiss) m_ring = 1'b0;
      else if (snooze) begin
        m_ring = 1'b0; m_snz = 1'b1; m_snooze_left = SNOOZE_MIN * 60;
      end else if (adv) begin
        m_ring_secs++;
        if (m_ring_secs == RING_TIMEOUT_S) m_ring = 1'b0;
      end
    end else if (m_snz) begin
      if (dismiss) m_snz = 1'b0;
      else if (adv) begin
        m_snooze_left--;
        if (m_snooze_left == 0) begin
          m_snz = 1'b0; m_ring = 1'b1; m_ring_secs = 0;
        end
      end
    end else if (hit) begin
      m_ring = 1'b1; m_ring_secs = 0;
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 ns later, strobes drop.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_vec(), model_vec());
    if (sec_pulse) pulse_cnt++;
    set_time = 1'b0; set_alarm = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic do_tick();
    tick_in = 1'b1; cycle();
    tick_in = 1'b0; cycle();
  endtask

  task automatic load_time(input int h, input int m);
    set_hour = 5'(h); set_min = 6'(m); set_time = 1'b1; cycle();
  endtask

  task automatic load_alarm(input int h, input int m);
    set_hour = 5'(h); set_min = 6'(m); set_alarm = 1'b1; cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; model_reset();
    tick_in = 1'b0; alarm_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic ring_at_seven();
    load_time(6, 59);
    repeat (60) do_tick();
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #2 check("reset_state", dut_vec(), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic counting.
    pulse_cnt = 0;
    repeat (3) do_tick();
    check("count3_time", dut_hms(), exp_hms(0, 0, 3));
    check("count3_pulses", 32'(pulse_cnt), 32'd3);
    check("count3_ring", {31'd0, alarm_ring}, 32'd0);

    // Directed table: {tick, st, sa, h, m, en, snz, dis | hh, mm, ss, pulse, ring, snoozing}
    tbl[0]  = '{1, 0, 0,  0,  0, 0, 0, 0,   0,  0, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 0,  0,  0, 0, 0, 0,   0,  0, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,  0,  0, 0, 0, 0,   0,  0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 23, 59, 0, 0, 0,  23, 59, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 24,  0, 0, 0, 0,  23, 59, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 10, 60, 0, 0, 0,  23, 59, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0,  0,  0, 0, 0, 0,  23, 59, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 0,  0,  0, 0, 0, 0,  23, 59, 1, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 12, 34, 0, 0, 0,  12, 34, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0,  0,  0, 0, 0, 0,  12, 34, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0,  0,  0, 0, 0, 0,  12, 34, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 12, 34, 1, 0, 0,  12, 34, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 12, 33, 1, 0, 0,  12, 33, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0,  0,  0, 1, 0, 0,  12, 33, 1, 1, 0, 0};
    tbl[14] = '{0, 0, 1, 31,  0, 1, 0, 0,  12, 33, 1, 0, 0, 0};
    tbl[15] = '{0, 0, 0,  0,  0, 1, 1, 0,  12, 33, 1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick_in   = (tbl[i].tick != 0);
      set_time  = (tbl[i].st != 0);
      set_alarm = (tbl[i].sa != 0);
      set_hour  = 5'(tbl[i].h);
      set_min   = 6'(tbl[i].m);
      alarm_en  = (tbl[i].en != 0);
      snooze    = (tbl[i].snz != 0);
      dismiss   = (tbl[i].dis != 0);
      cycle();
      check($sformatf("table_%0d", i), dut_vec(),
            exp_vec(tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].ep, tbl[i].er, tbl[i].esn));
    end
    tick_in = 1'b0;
    alarm_en = 1'b0;
    cycle();

    // Full-day rollover.
    load_time(23, 59);
    repeat (59) do_tick();
    check("rollover_59", dut_hms(), exp_hms(23, 59, 59));
    do_tick();
    check("rollover_wrap", dut_hms(), exp_hms(0, 0, 0));

    // Match and ring timeout.
    do_reset();
    alarm_en = 1'b1;
    load_alarm(7, 0);
    load_time(6, 59);
    repeat (58) do_tick();
    check("pre_match_time", dut_hms(), exp_hms(6, 59, 58));
    do_tick();
    check("pre_match_ring", {31'd0, alarm_ring}, 32'd0);
    tick_in = 1'b1; cycle();
    check("match_edge", dut_vec(), exp_vec(7, 0, 0, 1, 1, 0));
    tick_in = 1'b0; cycle();
    repeat (59) do_tick();
    check("ring_before_timeout", {31'd0, alarm_ring}, 32'd1);
    do_tick();
    check("ring_timeout", dut_vec(), exp_vec(7, 1, 0, 0, 0, 0));

    // Snooze, full snooze period, re-ring.
    ring_at_seven();
    check("snooze_ring", {31'd0, alarm_ring}, 32'd1);
    snooze = 1'b1; cycle();
    check("snooze_enter", {30'd0, alarm_ring, snoozing}, 32'd1);
    repeat (299) do_tick();
    check("snooze_299", {30'd0, alarm_ring, snoozing}, 32'd1);
    tick_in = 1'b1; cycle();
    check("snooze_expire", dut_vec(), exp_vec(7, 5, 0, 1, 1, 0));
    tick_in = 1'b0; cycle();

    // Dismiss beats snooze in the same cycle.
    dismiss = 1'b1; snooze = 1'b1; cycle();
    check("dismiss_over_snooze", {30'd0, alarm_ring, snoozing}, 32'd0);

    // Snooze ignored while snoozed; alarm_en drop forces IDLE.
    ring_at_seven();
    snooze = 1'b1; cycle();
    do_tick();
    snooze = 1'b1; cycle();
    check("snooze_in_snoozed", {30'd0, alarm_ring, snoozing}, 32'd1);
    alarm_en = 1'b0; cycle();
    check("en_drop_snoozed", {30'd0, alarm_ring, snoozing}, 32'd0);

    // Disarmed at the match instant.
    ring_at_seven();
    check("disarmed_match", dut_vec(), exp_vec(7, 0, 0, 0, 0, 0));

    // Asynchronous reset while ringing, then tick_in already high at release.
    alarm_en = 1'b1;
    ring_at_seven();
    check("async_pre_ring", {31'd0, alarm_ring}, 32'd1);
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_reset_clear", dut_vec(), 32'd0);
    tick_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    cycle();
    check("tick_at_release", dut_vec(), exp_vec(0, 0, 1, 1, 0, 0));
    tick_in = 1'b0; cycle();

    // Randomized traffic against the model.
    do_reset();
    alarm_en = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      int r, nm;
      tick_in  = ($urandom_range(0, 1) == 1);
      alarm_en = ($urandom_range(0, 199) != 0);
      snooze   = ($urandom_range(0, 99) == 0);
      dismiss  = ($urandom_range(0, 99) == 0);
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        set_time = 1'b1;
        set_hour = 5'($urandom_range(0, 31));
        set_min  = 6'($urandom_range(0, 63));
      end else if (r < 3) begin
        nm = (m_t / 60 + 1) % 1440;
        set_alarm = 1'b1;
        set_hour  = ($urandom_range(0, 7) == 0) ? 5'd24 : 5'(nm / 60);
        set_min   = 6'(nm % 60);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
